// File: rtl/imm_gen_pipe_if.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe_if
//   Handshake bundle between the fetch/decode boundary, the registered
//   immediate generator and the register-read stage.
//
//   Upstream side : in_valid, in_ready, instr, in_pc
//   Downstream side: out_valid, out_ready, out_imm, out_fmt, out_pc
//
//   modport slave  : the immediate generator itself
//   modport master : the surrounding pipeline (producer + consumer)
// ----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [PC_W-1:0] out_pc;

    modport slave (
        input  in_valid, instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_pc
    );

    modport master (
        output in_valid, instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_pc
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered, handshaked RISC-V immediate generator. Decodes I/S/B/U/J
//   immediates from the raw instruction word, sign-extends them from
//   instr[31] to XLEN and tags each with a format code. A main register (M)
//   drives the outputs and a skid register (K) absorbs the one extra entry
//   that can arrive while M is stalled, so in_ready comes straight from a
//   flop and never depends on out_ready combinationally.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset, aborts all buffered entries
//     flush  : synchronous kill of M and K; an input offered alongside it
//              is discarded
//     bus    : imm_gen_pipe_if.slave
//                in_valid/in_ready/instr/in_pc   upstream handshake
//                out_valid/out_ready/out_imm/out_fmt/out_pc downstream
//
//   out_fmt codes: 0=I 1=S 2=B 3=U 4=J 5=Z(CSR uimm) 7=NONE
//
//   Build option: define IMM_GEN_ZICSR_EN to decode SYSTEM (1110011)
//   instructions: funct3[2]=1 gives the zero-extended CSR uimm (fmt 5),
//   funct3[2]=0 gives an I-type immediate. Without it SYSTEM decodes as
//   NONE and fmt 5 is never produced.
// ----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd5;
`endif
    localparam logic [2:0] FMT_NONE = 3'd7;

    function automatic logic [2:0] dec_fmt(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: dec_fmt = FMT_I;
            7'b0100011:                         dec_fmt = FMT_S;
            7'b1100011:                         dec_fmt = FMT_B;
            7'b0110111, 7'b0010111:             dec_fmt = FMT_U;
            7'b1101111:                         dec_fmt = FMT_J;
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011:                         dec_fmt = i[14] ? FMT_Z : FMT_I;
`endif
            default:                            dec_fmt = FMT_NONE;
        endcase
    endfunction

    // Widen a 32-bit immediate to XLEN by replicating bit 31; this is also
    // what makes U-type sign-extend from bit 31 on RV64.
    function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s      = v;
        sext32 = XLEN'(s);
    endfunction

    function automatic logic signed [XLEN-1:0] dec_imm(input logic [31:0] i,
                                                       input logic [2:0]  fmt);
        dec_imm = '0;
        case (fmt)
            FMT_I: dec_imm = sext32({{20{i[31]}}, i[31:20]});
            FMT_S: dec_imm = sext32({{20{i[31]}}, i[31:25], i[11:7]});
            FMT_B: dec_imm = sext32({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
            FMT_U: dec_imm = sext32({i[31:12], 12'b0});
            FMT_J: dec_imm = sext32({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
`ifdef IMM_GEN_ZICSR_EN
            FMT_Z: dec_imm[4:0] = i[19:15];
`endif
            default: dec_imm = '0;
        endcase
    endfunction

    // ---- stage p0: combinational decode of the offered instruction ----
    logic signed [XLEN-1:0] imm_p0;
    logic [2:0]             fmt_p0;
    logic                   accept_p0;

    // ---- stage p1: main register M and skid register K ----
    logic signed [XLEN-1:0] imm_p1;
    logic [2:0]             fmt_p1;
    logic [PC_W-1:0]        pc_p1;
    logic                   vld_p1;

    logic signed [XLEN-1:0] skid_imm_p1;
    logic [2:0]             skid_fmt_p1;
    logic [PC_W-1:0]        skid_pc_p1;
    logic                   skid_vld_p1;

    logic                   m_open;

    always_comb begin
        fmt_p0    = dec_fmt(bus.instr);
        imm_p0    = dec_imm(bus.instr, fmt_p0);
        // in_ready is just !K.valid, so the accept never looks at out_ready.
        accept_p0 = bus.in_valid && !skid_vld_p1 && !flush;
        // M can take a new entry when it is empty or being consumed now.
        m_open    = !vld_p1 || bus.out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            imm_p1      <= '0;
            fmt_p1      <= FMT_NONE;
            pc_p1       <= '0;
            skid_vld_p1 <= 1'b0;
            skid_imm_p1 <= '0;
            skid_fmt_p1 <= FMT_NONE;
            skid_pc_p1  <= '0;
        end else if (flush) begin
            // Data registers keep their last values; only validity dies.
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (m_open) begin
            if (skid_vld_p1) begin
                // K is older than anything upstream; no accept is possible
                // this cycle because in_ready is low while K is full.
                vld_p1      <= 1'b1;
                imm_p1      <= skid_imm_p1;
                fmt_p1      <= skid_fmt_p1;
                pc_p1       <= skid_pc_p1;
                skid_vld_p1 <= 1'b0;
            end else if (accept_p0) begin
                vld_p1 <= 1'b1;
                imm_p1 <= imm_p0;
                fmt_p1 <= fmt_p0;
                pc_p1  <= bus.in_pc;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (accept_p0) begin
            // M is stalled: park the new entry in K.
            skid_vld_p1 <= 1'b1;
            skid_imm_p1 <= imm_p0;
            skid_fmt_p1 <= fmt_p0;
            skid_pc_p1  <= bus.in_pc;
        end
    end

    assign bus.in_ready  = !skid_vld_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_imm   = imm_p1;
    assign bus.out_fmt   = fmt_p1;
    assign bus.out_pc    = pc_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    localparam int XLEN = 32;
    localparam int PC_W = 32;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [PC_W-1:0] pc;
    } ent_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_vec;
    int   n_err;

    imm_gen_pipe_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    imm_gen_pipe #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder: builds each immediate from the field weights with
    // arithmetic shifts on a 64-bit sign-extended copy of the instruction.
    function automatic ent_t ref_model(input logic [31:0] i, input logic [PC_W-1:0] pc);
        ent_t             e;
        logic signed [63:0] w;
        logic [63:0]      a20, a25, a31, v;
        w   = $signed({{32{i[31]}}, i});
        a20 = w >>> 20;
        a25 = w >>> 25;
        a31 = w >>> 31;
        v   = '0;
        e.fmt = 3'd7;
        e.pc  = pc;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: begin v = a20; e.fmt = 3'd0; end
            7'h23: begin v = (a25 << 5) | 64'(i[11:7]); e.fmt = 3'd1; end
            7'h63: begin
                v = (a31 << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
                e.fmt = 3'd2;
            end
            7'h37, 7'h17: begin v = w & ~64'hFFF; e.fmt = 3'd3; end
            7'h6F: begin
                v = (a31 << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
                e.fmt = 3'd4;
            end
`ifdef IMM_GEN_ZICSR_EN
            7'h73: begin
                if (i[14]) begin v = 64'(i[19:15]); e.fmt = 3'd5; end
                else       begin v = a20;           e.fmt = 3'd0; end
            end
`endif
            default: begin v = '0; e.fmt = 3'd7; end
        endcase
        e.imm = v[XLEN-1:0];
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 10))
            0: op = 7'h13;  1: op = 7'h03;  2: op = 7'h67;  3: op = 7'h23;
            4: op = 7'h63;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h6F;
            8: op = 7'h33;  9: op = 7'h73;  default: op = r[6:0];
        endcase
        return {r[31:7], op};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc);
        bus.in_valid = v;
        bus.instr    = ins;
        bus.in_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, '0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_vec++; if (bus.out_imm !== '0) begin n_err++; $display("FAIL reset_out_imm got %h exp 0", bus.out_imm); end
        n_vec++; if (bus.out_fmt !== 3'd7) begin n_err++; $display("FAIL reset_out_fmt got %0d exp 7", bus.out_fmt); end
        n_vec++; if (bus.out_pc !== '0) begin n_err++; $display("FAIL reset_out_pc got %h exp 0", bus.out_pc); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h0000_0100);
        @(negedge clk);
        drive(1'b0, 32'h0, '0);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid got %b exp 1", bus.out_valid); end
        n_vec++; if (bus.out_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL t1_imm got %h exp ffffffff", bus.out_imm); end
        n_vec++; if (bus.out_fmt !== 3'd0) begin n_err++; $display("FAIL t1_fmt got %0d exp 0", bus.out_fmt); end
        n_vec++; if (bus.out_pc !== 32'h0000_0100) begin n_err++; $display("FAIL t1_pc got %h exp 00000100", bus.out_pc); end
        @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t1_drained got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3];
        logic [31:0] imm [3];
        logic [2:0]  fmt [3];
        ins[0] = 32'hFE112E23; imm[0] = 32'hFFFFFFFC; fmt[0] = 3'd1;
        ins[1] = 32'hFE000CE3; imm[1] = 32'hFFFFFFF8; fmt[1] = 3'd2;
        ins[2] = 32'h0010006F; imm[2] = 32'h00000800; fmt[2] = 3'd4;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL t2_valid%0d got %b exp 1", k-1, bus.out_valid); end
                n_vec++; if (bus.out_imm !== imm[k-1]) begin n_err++; $display("FAIL t2_imm%0d got %h exp %h", k-1, bus.out_imm, imm[k-1]); end
                n_vec++; if (bus.out_fmt !== fmt[k-1]) begin n_err++; $display("FAIL t2_fmt%0d got %0d exp %0d", k-1, bus.out_fmt, fmt[k-1]); end
                n_vec++; if (bus.out_pc !== 32'(k-1) * 4) begin n_err++; $display("FAIL t2_pc%0d got %h exp %h", k-1, bus.out_pc, 32'(k-1) * 4); end
                n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t2_in_ready%0d got %b exp 1", k-1, bus.in_ready); end
            end
            if (k < 3) drive(1'b1, ins[k], 32'(k) * 4);
            else       drive(1'b0, 32'h0, '0);
        end
        @(negedge clk);
    endtask

    task automatic test_formats();
        logic [31:0] ins [4];
        logic [31:0] imm [4];
        logic [2:0]  fmt [4];
        ins[0] = 32'h123450B7; imm[0] = 32'h12345000; fmt[0] = 3'd3;
        ins[1] = 32'h002081B3; imm[1] = 32'h00000000; fmt[1] = 3'd7;
        ins[2] = 32'h0007D073;
        ins[3] = 32'h34011073;
`ifdef IMM_GEN_ZICSR_EN
        imm[2] = 32'h0000000F; fmt[2] = 3'd5;
        imm[3] = 32'h00000340; fmt[3] = 3'd0;
`else
        imm[2] = 32'h00000000; fmt[2] = 3'd7;
        imm[3] = 32'h00000000; fmt[3] = 3'd7;
`endif
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, ins[k], 32'h1000 + 32'(k));
            @(negedge clk);
            drive(1'b0, 32'h0, '0);
            n_vec++; if (bus.out_imm !== imm[k]) begin n_err++; $display("FAIL t3_imm%0d got %h exp %h", k, bus.out_imm, imm[k]); end
            n_vec++; if (bus.out_fmt !== fmt[k]) begin n_err++; $display("FAIL t3_fmt%0d got %0d exp %0d", k, bus.out_fmt, fmt[k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        ent_t        ea, eb, ec;
        logic [31:0] ia, ib, ic;
        ia = rand_instr(); ib = rand_instr(); ic = rand_instr();
        ea = ref_model(ia, 32'hA0); eb = ref_model(ib, 32'hB0); ec = ref_model(ic, 32'hC0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, ia, 32'hA0);
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t4_ready_after_a got %b exp 1", bus.in_ready); end
        n_vec++; if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_pc} !== {1'b1, ea}) begin
            n_err++; $display("FAIL t4_a_head got %h/%0d/%h exp %h/%0d/%h", bus.out_imm, bus.out_fmt, bus.out_pc, ea.imm, ea.fmt, ea.pc); end
        drive(1'b1, ib, 32'hB0);
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_after_b got %b exp 0", bus.in_ready); end
        n_vec++; if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_pc} !== {1'b1, ea}) begin
            n_err++; $display("FAIL t4_a_hold1 got %h/%0d/%h exp %h/%0d/%h", bus.out_imm, bus.out_fmt, bus.out_pc, ea.imm, ea.fmt, ea.pc); end
        drive(1'b1, ic, 32'hC0);
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_hold got %b exp 0", bus.in_ready); end
        n_vec++; if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_pc} !== {1'b1, ea}) begin
            n_err++; $display("FAIL t4_a_hold2 got %h/%0d/%h exp %h/%0d/%h", bus.out_imm, bus.out_fmt, bus.out_pc, ea.imm, ea.fmt, ea.pc); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t4_ready_reopen got %b exp 1", bus.in_ready); end
        n_vec++; if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_pc} !== {1'b1, eb}) begin
            n_err++; $display("FAIL t4_b_out got %h/%0d/%h exp %h/%0d/%h", bus.out_imm, bus.out_fmt, bus.out_pc, eb.imm, eb.fmt, eb.pc); end
        @(negedge clk);
        drive(1'b0, 32'h0, '0);
        n_vec++; if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_pc} !== {1'b1, ec}) begin
            n_err++; $display("FAIL t4_c_out got %h/%0d/%h exp %h/%0d/%h", bus.out_imm, bus.out_fmt, bus.out_pc, ec.imm, ec.fmt, ec.pc); end
        @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t4_drained got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        // Both M and K full, flush while offering an instruction.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h10);
        @(negedge clk);
        drive(1'b1, 32'h123450B7, 32'h14);
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t5_full got %b exp 0", bus.in_ready); end
        flush = 1'b1;
        drive(1'b1, 32'h0010006F, 32'h18);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, '0);
        bus.out_ready = 1'b1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t5_valid got %b exp 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t5_in_ready got %b exp 1", bus.in_ready); end
        @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t5_lost got %b exp 0", bus.out_valid); end
        // Only M full: the offered input would be accepted if not for flush.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFE112E23, 32'h20);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'hFE000CE3, 32'h24);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, '0);
        bus.out_ready = 1'b1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t5b_valid got %b exp 0", bus.out_valid); end
        @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t5b_lost got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_random();
        ent_t        q [$];
        ent_t        got, exp_e;
        logic [31:0] ins;
        logic [PC_W-1:0] pc;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            ins = rand_instr();
            pc  = $urandom();
            drive(1'($urandom_range(0, 3) != 0), ins, pc);
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 40) == 0);
            #1;
            n_vec++; if (bus.out_valid !== (q.size() != 0)) begin
                n_err++; $display("FAIL rnd_valid c%0d got %b exp %b", c, bus.out_valid, q.size() != 0); end
            n_vec++; if (bus.in_ready !== (q.size() < 2)) begin
                n_err++; $display("FAIL rnd_in_ready c%0d got %b exp %b", c, bus.in_ready, q.size() < 2); end
            if (flush) begin
                q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                    exp_e = q.pop_front();
                    got   = '{imm: bus.out_imm, fmt: bus.out_fmt, pc: bus.out_pc};
                    n_vec++; if (got !== exp_e) begin
                        n_err++; $display("FAIL rnd_data c%0d got %h/%0d/%h exp %h/%0d/%h", c, got.imm, got.fmt, got.pc, exp_e.imm, exp_e.fmt, exp_e.pc); end
                end
                if (bus.in_valid && bus.in_ready) q.push_back(ref_model(ins, pc));
            end
        end
        @(negedge clk);
        flush = 1'b1;
        drive(1'b0, 32'h0, '0);
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h40);
        @(negedge clk);
        drive(1'b1, 32'h0010006F, 32'h44);
        @(negedge clk);
        drive(1'b0, 32'h0, '0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t6_out_valid got %b exp 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t6_in_ready got %b exp 1", bus.in_ready); end
        n_vec++; if (bus.out_imm !== '0) begin n_err++; $display("FAIL t6_out_imm got %h exp 0", bus.out_imm); end
        n_vec++; if (bus.out_fmt !== 3'd7) begin n_err++; $display("FAIL t6_out_fmt got %0d exp 7", bus.out_fmt); end
        n_vec++; if (bus.out_pc !== '0) begin n_err++; $display("FAIL t6_out_pc got %h exp 0", bus.out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t6_aborted got %b exp 0", bus.out_valid); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_formats();
        test_stall();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
